// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing presets, control payload type and total-length helper.
package vga_pkg;

    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 33;

    localparam int VGA800_H_ACTIVE = 800;
    localparam int VGA800_H_FP     = 40;
    localparam int VGA800_H_SYNC   = 128;
    localparam int VGA800_H_BP     = 88;
    localparam int VGA800_V_ACTIVE = 600;
    localparam int VGA800_V_FP     = 1;
    localparam int VGA800_V_SYNC   = 4;
    localparam int VGA800_V_BP     = 23;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } vga_ctl_t;

    function automatic int vga_total(input int sync, input int bp, input int active, input int fp);
        return sync + bp + active + fp;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: DEPTH+1 register shift of active-high sync/DE flags, advancing on en_i.
module vga_delay_line
    import vga_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     en_i,
    input  vga_ctl_t d_i,
    output vga_ctl_t q_o
);

    vga_ctl_t stage_q [DEPTH+1];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i <= DEPTH; i++) stage_q[i] <= '0;
        end else if (en_i) begin
            stage_q[0] <= d_i;
            for (int i = 1; i <= DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[DEPTH];

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster counters, stage-0 coordinates/strobes and delayed sync/DE.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA640_H_ACTIVE,
    parameter int H_FP     = VGA640_H_FP,
    parameter int H_SYNC   = VGA640_H_SYNC,
    parameter int H_BP     = VGA640_H_BP,
    parameter int V_ACTIVE = VGA640_V_ACTIVE,
    parameter int V_FP     = VGA640_V_FP,
    parameter int V_SYNC   = VGA640_V_SYNC,
    parameter int V_BP     = VGA640_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int DELAY    = 2,
    parameter int CW       = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_en,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          fetch,
    output logic          line_start,
    output logic          frame_start,
    output logic          hsync,
    output logic          vsync,
    output logic          de
);

    localparam int H_TOTAL = vga_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
    localparam int V_TOTAL = vga_total(V_SYNC, V_BP, V_ACTIVE, V_FP);

    localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] HS_END  = CW'(H_SYNC);
    localparam logic [CW-1:0] VS_END  = CW'(V_SYNC);
    localparam logic [CW-1:0] HA_LO   = CW'(H_SYNC + H_BP);
    localparam logic [CW-1:0] HA_HI   = CW'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [CW-1:0] VA_LO   = CW'(V_SYNC + V_BP);
    localparam logic [CW-1:0] VA_HI   = CW'(V_SYNC + V_BP + V_ACTIVE);

    if (H_TOTAL > 2**CW || V_TOTAL > 2**CW) begin : g_cw_check
        $error("vga_timing_gen: CW too narrow for the line/frame totals");
    end
    if (DELAY < 0 || DELAY > 15) begin : g_delay_check
        $error("vga_timing_gen: DELAY out of range 0..15");
    end
    if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_width_check
        $error("vga_timing_gen: porch and sync widths must be at least 1");
    end

    logic [CW-1:0] h_q, h_d, v_q, v_d, x_q, x_d, y_q, y_d;
    logic          fetch_q, line_q, frame_q, h_end;
    vga_ctl_t      raw, ctl;

    always_comb begin
        h_end  = h_q == H_LAST;
        h_d    = h_end ? '0 : h_q + 1'b1;
        v_d    = h_end ? (v_q == V_LAST ? '0 : v_q + 1'b1) : v_q;
        raw.hs = h_q < HS_END;
        raw.vs = v_q < VS_END;
        raw.de = h_q >= HA_LO && h_q < HA_HI && v_q >= VA_LO && v_q < VA_HI;
        x_d    = raw.de ? h_q - HA_LO : '0;
        y_d    = raw.de ? v_q - VA_LO : '0;
    end

    // Stage 0 samples the pre-increment counters, so it lags them by one tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_q     <= '0;
            v_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            fetch_q <= 1'b0;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
        end else if (pix_en) begin
            h_q     <= h_d;
            v_q     <= v_d;
            x_q     <= x_d;
            y_q     <= y_d;
            fetch_q <= raw.de;
            line_q  <= h_q == '0;
            frame_q <= h_q == '0 && v_q == '0;
        end
    end

    vga_delay_line #(.DEPTH(DELAY)) u_delay (
        .clk   (clk),
        .reset (reset),
        .en_i  (pix_en),
        .d_i   (raw),
        .q_o   (ctl)
    );

    assign x           = x_q;
    assign y           = y_q;
    assign fetch       = fetch_q;
    assign line_start  = line_q;
    assign frame_start = frame_q;
    assign hsync       = ctl.hs ~^ HS_POL;
    assign vsync       = ctl.vs ~^ VS_POL;
    assign de          = ctl.de;

endmodule
